// File: rtl/serial_parity_rx.sv
// serial_parity_rx: receive end of the parity-protected serial byte link.
// Frame format: start(0), DATA_W data bits LSB first, parity, stop(1).
// The received word, its parity/framing flags and an overrun pulse are
// presented on a valid/ready output port.
// Build option: define SERIAL_PARITY_RX_ERRCNT_EN to build the saturating
// error counter; otherwise err_count is tied to zero.
//
// state  | meaning
// -------+------------------------------------------------------
// IDLE   | line idle, waiting for a start bit (sin=0 on a strobe)
// DATA   | shifting in data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | sampling the stop bit and completing the frame
module serial_parity_rx #(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    input  logic              sin_valid,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic [CNT_W-1:0]  err_count
);

    localparam int BCW = $clog2(DATA_W);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);
    localparam logic PAR_INV = (PARITY_ODD != 0);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [BCW-1:0]    bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              pbit_q, pbit_d;
    logic              frame_done;

    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;

    logic              new_perr;
    logic              new_ferr;
    logic              load;
    logic              drop;

    // Deserialiser state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            pbit_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            pbit_q   <= pbit_d;
        end
    end

    // Frame FSM: advances only on bit strobes
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        pbit_d     = pbit_q;
        frame_done = 1'b0;
        if (sin_valid) begin
            case (state_q)
                IDLE: begin
                    if (!sin) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                        shift_d  = '0;
                    end
                end
                DATA: begin
                    shift_d[bitcnt_q] = sin;
                    if (bitcnt_q == LAST_BIT) begin
                        state_d = PARITY;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    pbit_d  = sin;
                    state_d = STOP;
                end
                STOP: begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // The stop bit is the current sin on the completing strobe
    assign new_perr = pbit_q != ((^shift_q) ^ PAR_INV);
    assign new_ferr = ~sin;
    // A completing frame loads if the slot is empty or being accepted this cycle
    assign load     = frame_done & (~dout_valid_q | dout_ready);
    assign drop     = frame_done & dout_valid_q & ~dout_ready;

    // Output slot next-state: load, accept or hold
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = drop;
        if (load) begin
            dout_d       = shift_q;
            dout_valid_d = 1'b1;
            parity_err_d = new_perr;
            frame_err_d  = new_ferr;
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    // Output slot registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

`ifdef SERIAL_PARITY_RX_ERRCNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_inc;

    // Load and drop are exclusive, so at most one event per cycle
    assign cnt_inc = (load & (new_perr | new_ferr)) | drop;

    // Saturating error count
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Error counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_count = cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_serial_parity_rx.sv
// Testbench for serial_parity_rx (DATA_W=8, PARITY_ODD=0, CNT_W=2).
// Stimulus pushes expected words into a queue; a monitor pops them on each
// accepted output.
module tb_serial_parity_rx;

    localparam int DW = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          sin;
    logic          sin_valid;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          parity_err;
    logic          frame_err;
    logic          overrun;
    logic [CW-1:0] err_count;

    serial_parity_rx #(.DATA_W(DW), .PARITY_ODD(0), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ovr_seen = 0;
    int   exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp();
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
        return 32'(exp_cnt);
`else
        return 32'd0;
`endif
    endfunction

    task automatic bump();
        if (exp_cnt < 3) exp_cnt++;
    endtask

    // Monitor: count overrun pulses, pop and compare every accepted word
    always @(negedge clk) begin
        if (!rst) begin
            if (overrun) ovr_seen++;
            if (dout_valid && dout_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got dout=%0h with no word expected", dout);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("dout", 32'(dout), 32'(e.d));
                    chk("parity_err", 32'(parity_err), 32'(e.pe));
                    chk("frame_err", 32'(frame_err), 32'(e.fe));
                end
            end
        end
    end

    task automatic strobe(input logic b);
        @(posedge clk); #1;
        sin       = b;
        sin_valid = 1'b1;
        @(posedge clk); #1;
        sin_valid = 1'b0;
        sin       = 1'b1;
    endtask

    // Full frame; expected flags are hand-computed by the caller
    task automatic send(input logic [7:0] d, input logic p, input logic s,
                        input logic pe, input logic fe, input bit push);
        strobe(1'b0);
        for (int i = 0; i < 8; i++) strobe(d[i]);
        strobe(p);
        if (push) q.push_back('{d: d, pe: pe, fe: fe});
        strobe(s);
    endtask

    initial begin
        int o0;
        rst        = 1'b1;
        sin        = 1'b1;
        sin_valid  = 1'b0;
        dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_valid", 32'(dout_valid), 32'h0);
        chk("rst_perr", 32'(parity_err), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_errcnt", 32'(err_count), 32'h0);
        rst = 1'b0;

        // 1: good frame A5, valid right after the stop strobe
        send(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t1_valid_latency", 32'(dout_valid), 32'h1);
        chk("t1_errcnt", 32'(err_count), cnt_exp());
        repeat (2) @(posedge clk);

        // 2: parity error (07 has odd ones, parity sent 0)
        send(8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        bump();
        chk("t2_errcnt", 32'(err_count), cnt_exp());

        // 3: framing error
        send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        bump();
        chk("t3_errcnt", 32'(err_count), cnt_exp());

        // extra good patterns
        send(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        send(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        send(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("good_errcnt", 32'(err_count), cnt_exp());
        repeat (2) @(posedge clk);

        // 4: overrun with consumer stalled
        dout_ready = 1'b0;
        o0 = ovr_seen;
        send(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        send(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        bump();
        chk("t4_overrun_pulses", 32'(ovr_seen - o0), 32'd1);
        chk("t4_dout_held", 32'(dout), 32'h5A);
        chk("t4_valid_held", 32'(dout_valid), 32'h1);
        chk("t4_errcnt", 32'(err_count), cnt_exp());
        dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_valid_cleared", 32'(dout_valid), 32'h0);

        // 5: reset mid-frame, then a clean frame
        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_rst_valid", 32'(dout_valid), 32'h0);
        chk("t5_rst_errcnt", 32'(err_count), 32'h0);
        rst = 1'b0;
        exp_cnt = 0;
        send(8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t5_errcnt", 32'(err_count), cnt_exp());
        repeat (2) @(posedge clk);

        // 6: five error frames saturate the counter
        for (int i = 0; i < 5; i++) begin
            send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            bump();
        end
        chk("t6_errcnt_sat", 32'(err_count), cnt_exp());

        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

endmodule
